uart_stream_bridge: RTL and testbench

// Avalon-MM master that drives the RS232 core (RXDATA @0, TXDATA @4, STATUS @8) in full duplex.
// TX side: byte-stream input buffered in a parametrised FIFO. RX side: assembles RX_WORD_BYTES

---
 rtl/uart_stream_bridge.sv | 181 ++++++++++++++++++
 tb/tb_uart_stream_bridge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_bridge.sv
// Full-duplex Avalon-MM master for the RS232 core: TX byte FIFO, RX word assembly.
// Optional status error handling is enabled by defining UART_BRIDGE_ERRCHK_EN.
module uart_stream_bridge #(
    parameter int TX_DEPTH      = 16,
    parameter int RX_WORD_BYTES = 2,
    parameter int OFF_RXDATA    = 0,
    parameter int OFF_TXDATA    = 4,
    parameter int OFF_STATUS    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic [4:0]                   o_address,
    output logic                         o_read,
    input  logic [31:0]                  i_readdata,
    output logic                         o_write,
    output logic [31:0]                  o_writedata,
    input  logic                         i_waitrequest,
    input  logic                         i_tx_valid,
    output logic                         o_tx_ready,
    input  logic [7:0]                   i_tx_data,
    output logic                         o_rx_valid,
    output logic [8*RX_WORD_BYTES-1:0]   o_rx_data,
    output logic [$clog2(TX_DEPTH):0]    o_tx_level
`ifdef UART_BRIDGE_ERRCHK_EN
    ,
    output logic [7:0]                   o_err_cnt
`endif
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = (RX_WORD_BYTES > 1) ? $clog2(RX_WORD_BYTES) : 1;
    localparam int RW = 8 * RX_WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_RXRD,
`ifdef UART_BRIDGE_ERRCHK_EN
        S_CLR,
`endif
        S_TXWR
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [TX_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   rx_buf_q, rx_data_q, rx_word;
    logic            rx_valid_q;
    logic            push, pop, rx_done, rx_last, fifo_empty;
    logic            unused_ok;
`ifdef UART_BRIDGE_ERRCHK_EN
    logic [7:0]      err_cnt_q;
    logic            clr_done;
`endif

    assign fifo_empty = (level_q == '0);
    assign o_tx_ready = (level_q != (AW+1)'(TX_DEPTH));
    assign push       = i_tx_valid & o_tx_ready;
    assign pop        = (state_q == S_TXWR) & ~i_waitrequest;
    assign rx_done    = (state_q == S_RXRD) & ~i_waitrequest;
    assign rx_last    = (cnt_q == CW'(RX_WORD_BYTES - 1));
    assign o_tx_level = level_q;
    assign o_rx_valid = rx_valid_q;
    assign o_rx_data  = rx_data_q;
    assign unused_ok  = ^{i_readdata[31:8], i_readdata[5:0]};
`ifdef UART_BRIDGE_ERRCHK_EN
    assign clr_done   = (state_q == S_CLR) & ~i_waitrequest;
    assign o_err_cnt  = err_cnt_q;
`endif

    // Bus phase is a pure function of state, so it holds during waitrequest.
    always_comb begin
        state_d     = state_q;
        o_read      = 1'b0;
        o_write     = 1'b0;
        o_address   = OFF_STATUS[4:0];
        o_writedata = '0;
        unique case (state_q)
            S_IDLE: state_d = S_POLL;
            S_POLL: begin
                o_read = 1'b1;
                if (!i_waitrequest) begin
`ifdef UART_BRIDGE_ERRCHK_EN
                    if (|i_readdata[3:0]) state_d = S_CLR;
                    else
`endif
                    if (i_readdata[7]) state_d = S_RXRD;
                    else if (i_readdata[6] && !fifo_empty) state_d = S_TXWR;
                    else state_d = S_IDLE;
                end
            end
            S_RXRD: begin
                o_read    = 1'b1;
                o_address = OFF_RXDATA[4:0];
                if (!i_waitrequest) state_d = S_POLL;
            end
            S_TXWR: begin
                o_write     = 1'b1;
                o_address   = OFF_TXDATA[4:0];
                o_writedata = {24'b0, mem[rd_ptr_q[AW-1:0]]};
                if (!i_waitrequest) state_d = S_POLL;
            end
`ifdef UART_BRIDGE_ERRCHK_EN
            S_CLR: begin
                o_write = 1'b1;
                if (!i_waitrequest) state_d = S_POLL;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Drop the received byte into the slot selected by the byte count.
    always_comb begin
        rx_word = rx_buf_q;
        for (int b = 0; b < RX_WORD_BYTES; b++) begin
            if (cnt_q == CW'(b)) rx_word[b*8 +: 8] = i_readdata[7:0];
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FIFO storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= i_tx_data;
    end

    // FIFO pointers and registered occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    // RX word assembly; a status clear discards a partial word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q      <= '0;
            rx_buf_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rx_done) begin
                rx_buf_q <= rx_word;
                if (rx_last) begin
                    rx_data_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                    cnt_q      <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
`ifdef UART_BRIDGE_ERRCHK_EN
            if (clr_done) cnt_q <= '0;
`endif
        end
    end

`ifdef UART_BRIDGE_ERRCHK_EN
    // Saturating count of cleared status errors.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) err_cnt_q <= '0;
        else if (clr_done && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
`endif

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: Avalon slave model of the RS232 core plus
// scoreboards for TX writes and assembled RX words.
module tb_uart_stream_bridge;

    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    o_address;
    logic          o_read, o_write;
    logic [31:0]   i_readdata = '0;
    logic [31:0]   o_writedata;
    logic          i_waitrequest = 1'b0;
    logic          i_tx_valid = 1'b0;
    logic          o_tx_ready;
    logic [7:0]    i_tx_data = '0;
    logic          o_rx_valid;
    logic [RW-1:0] o_rx_data;
    logic [4:0]    o_tx_level;
`ifdef UART_BRIDGE_ERRCHK_EN
    logic [7:0]    o_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic          trdy = 1'b0;
    logic [3:0]    err_bits = '0;
    int            clr_base = 0;
    int            clr_seen = 0;
    logic [31:0]   clr_data = '0;
    logic [7:0]    rx_q[$];
    logic [31:0]   obs_wr[$];
    logic [7:0]    exp_tx[$];
    logic [RW-1:0] obs_rx[$];
    logic [RW-1:0] exp_rx[$];
    logic [7:0]    order_q[$];
    int            tx_stall = 0;
    int            stall_ctr = 0;
    int            stall_seen = 0;
    int            stab_err = 0;
    logic [4:0]    hold_addr;
    logic [31:0]   hold_data;
    logic [31:0]   rd;

    uart_stream_bridge dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .o_address(o_address),
        .o_read(o_read),
        .i_readdata(i_readdata),
        .o_write(o_write),
        .o_writedata(o_writedata),
        .i_waitrequest(i_waitrequest),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .i_tx_data(i_tx_data),
        .o_rx_valid(o_rx_valid),
        .o_rx_data(o_rx_data),
`ifdef UART_BRIDGE_ERRCHK_EN
        .o_err_cnt(o_err_cnt),
`endif
        .o_tx_level(o_tx_level)
    );

    always #5 clk = ~clk;

    // Slave model: responds at the negedge, transfer completes at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_ctr     = 0;
            i_waitrequest = 1'b0;
            i_readdata    = '0;
        end else begin
            rd = '0;
            if (o_read && o_address == 5'd8)
                rd = {24'b0, (rx_q.size() != 0), trdy, 2'b00,
                      (clr_seen == clr_base) ? err_bits : 4'h0};
            else if (o_read && o_address == 5'd0 && rx_q.size() != 0)
                rd = {24'b0, rx_q[0]};
            i_readdata    = rd;
            i_waitrequest = 1'b0;
            if (o_write && o_address == 5'd4) begin
                if (stall_ctr > 0 && (o_address !== hold_addr ||
                    o_writedata !== hold_data)) stab_err++;
                hold_addr = o_address;
                hold_data = o_writedata;
                if (stall_ctr < tx_stall) begin
                    i_waitrequest = 1'b1;
                    stall_ctr++;
                    stall_seen++;
                end
            end
            if ((o_read || o_write) && !i_waitrequest) begin
                if (o_read && o_address == 5'd0) begin
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                    order_q.push_back(8'h52);
                end
                if (o_write && o_address == 5'd4) begin
                    obs_wr.push_back(o_writedata);
                    order_q.push_back(8'h54);
                    stall_ctr = 0;
                end
                if (o_write && o_address == 5'd8) begin
                    clr_seen++;
                    clr_data = o_writedata;
                end
            end
            if (o_rx_valid) obs_rx.push_back(o_rx_data);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_tx_valid = 1'b1;
        i_tx_data  = b;
        if (o_tx_ready) exp_tx.push_back(b);
        @(posedge clk); #1;
        i_tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", o_read); end
        checks++; if (o_write !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", o_write); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rxvalid got %b exp 0", o_rx_valid); end
        checks++; if (o_address !== 5'd8) begin errors++; $display("FAIL rst_addr got %0d exp 8", o_address); end
        checks++; if (o_rx_data !== '0) begin errors++; $display("FAIL rst_rxdata got %h exp 0", o_rx_data); end
        checks++; if (o_tx_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", o_tx_level); end
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", o_tx_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_read !== 1'b1) begin errors++; $display("FAIL rst_poll got %b exp 1", o_read); end
    endtask

    task automatic test_tx_basic;
        trdy = 1'b0;
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        @(posedge clk); #1;
        checks++; if (o_tx_level !== 5'd3) begin errors++; $display("FAIL t1_level got %0d exp 3", o_tx_level); end
        trdy = 1'b1;
        for (int i = 0; i < 300 && obs_wr.size() < 3; i++) @(posedge clk);
        #1;
        checks++; if (obs_wr.size() != 3) begin errors++; $display("FAIL t1_count got %0d exp 3", obs_wr.size()); end
        while (obs_wr.size() != 0 && exp_tx.size() != 0) begin
            logic [31:0] o, e;
            o = obs_wr.pop_front();
            e = {24'b0, exp_tx.pop_front()};
            checks++; if (o !== e) begin errors++; $display("FAIL t1_data got %h exp %h", o, e); end
        end
        repeat (2) @(posedge clk); #1;
        checks++; if (o_tx_level !== 5'd0) begin errors++; $display("FAIL t1_drained got %0d exp 0", o_tx_level); end
    endtask

    task automatic test_fifo_full;
        trdy = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
        #1;
        checks++; if (o_tx_level !== 5'd16) begin errors++; $display("FAIL t2_level got %0d exp 16", o_tx_level); end
        checks++; if (o_tx_ready !== 1'b0) begin errors++; $display("FAIL t2_ready got %b exp 0", o_tx_ready); end
        push_byte(8'hEE);
        checks++; if (o_tx_level !== 5'd16) begin errors++; $display("FAIL t2_ovf got %0d exp 16", o_tx_level); end
        trdy = 1'b1;
        for (int i = 0; i < 300 && obs_wr.size() < 1; i++) @(posedge clk);
        #1;
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_back got %b exp 1", o_tx_ready); end
        for (int i = 0; i < 600 && obs_wr.size() < 16; i++) @(posedge clk);
        repeat (10) @(posedge clk); #1;
        checks++; if (obs_wr.size() != 16) begin errors++; $display("FAIL t2_count got %0d exp 16", obs_wr.size()); end
        while (obs_wr.size() != 0 && exp_tx.size() != 0) begin
            logic [31:0] o, e;
            o = obs_wr.pop_front();
            e = {24'b0, exp_tx.pop_front()};
            checks++; if (o !== e) begin errors++; $display("FAIL t2_data got %h exp %h", o, e); end
        end
    endtask

    task automatic test_rx_priority;
        logic [7:0] exp_order[4];
        exp_order = '{8'h52, 8'h52, 8'h54, 8'h54};
        trdy = 1'b0;
        push_byte(8'h51); push_byte(8'h52);
        order_q.delete();
        rx_q.push_back(8'h34);
        rx_q.push_back(8'h12);
        exp_rx.push_back(16'h1234);
        trdy = 1'b1;
        for (int i = 0; i < 300 && obs_wr.size() < 2; i++) @(posedge clk);
        repeat (10) @(posedge clk); #1;
        checks++; if (order_q.size() != 4) begin errors++; $display("FAIL t3_ops got %0d exp 4", order_q.size()); end
        for (int i = 0; i < 4 && i < order_q.size(); i++) begin
            checks++;
            if (order_q[i] !== exp_order[i]) begin
                errors++; $display("FAIL t3_order[%0d] got %c exp %c", i, order_q[i], exp_order[i]);
            end
        end
        checks++; if (obs_rx.size() != 1) begin errors++; $display("FAIL t3_pulses got %0d exp 1", obs_rx.size()); end
        while (obs_rx.size() != 0 && exp_rx.size() != 0) begin
            logic [RW-1:0] o, e;
            o = obs_rx.pop_front();
            e = exp_rx.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t3_word got %h exp %h", o, e); end
        end
        checks++; if (o_rx_data !== 16'h1234) begin errors++; $display("FAIL t3_hold got %h exp 1234", o_rx_data); end
        while (obs_wr.size() != 0 && exp_tx.size() != 0) begin
            logic [31:0] o, e;
            o = obs_wr.pop_front();
            e = {24'b0, exp_tx.pop_front()};
            checks++; if (o !== e) begin errors++; $display("FAIL t3_tx got %h exp %h", o, e); end
        end
    endtask

    task automatic test_waitrequest;
        tx_stall   = 3;
        stall_seen = 0;
        stab_err   = 0;
        trdy       = 1'b1;
        push_byte(8'h5A);
        for (int i = 0; i < 300 && obs_wr.size() < 1; i++) @(posedge clk);
        repeat (20) @(posedge clk); #1;
        tx_stall = 0;
        checks++; if (stall_seen != 3) begin errors++; $display("FAIL t4_stalls got %0d exp 3", stall_seen); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL t4_stable got %0d exp 0", stab_err); end
        checks++; if (obs_wr.size() != 1) begin errors++; $display("FAIL t4_single got %0d exp 1", obs_wr.size()); end
        while (obs_wr.size() != 0 && exp_tx.size() != 0) begin
            logic [31:0] o, e;
            o = obs_wr.pop_front();
            e = {24'b0, exp_tx.pop_front()};
            checks++; if (o !== e) begin errors++; $display("FAIL t4_data got %h exp %h", o, e); end
        end
        checks++; if (o_tx_level !== 5'd0) begin errors++; $display("FAIL t4_level got %0d exp 0", o_tx_level); end
    endtask

    task automatic test_reset_mid_tx;
        trdy = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        #1;
        checks++; if (o_tx_level !== 5'd5) begin errors++; $display("FAIL t5_level got %0d exp 5", o_tx_level); end
        tx_stall = 10000;
        trdy     = 1'b1;
        for (int i = 0; i < 100 && o_write !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        checks++; if (o_write !== 1'b1) begin errors++; $display("FAIL t5_txwr got %b exp 1", o_write); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_write !== 1'b0) begin errors++; $display("FAIL t5_write got %b exp 0", o_write); end
        checks++; if (o_tx_level !== 5'd0) begin errors++; $display("FAIL t5_flush got %0d exp 0", o_tx_level); end
        checks++; if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL t5_ready got %b exp 1", o_tx_ready); end
        trdy     = 1'b0;
        tx_stall = 0;
        exp_tx.delete();
        obs_wr.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (o_read !== 1'b0 || o_write !== 1'b0) begin
            errors++; $display("FAIL t5_idle got rd=%b wr=%b exp 0 0", o_read, o_write);
        end
        repeat (20) @(posedge clk); #1;
        checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL t5_nowrite got %0d exp 0", obs_wr.size()); end
    endtask

`ifdef UART_BRIDGE_ERRCHK_EN
    task automatic test_errchk;
        trdy = 1'b0;
        obs_rx.delete();
        rx_q.push_back(8'h77);
        for (int i = 0; i < 100 && rx_q.size() != 0; i++) @(posedge clk);
        repeat (6) @(posedge clk); #1;
        clr_base = clr_seen;
        err_bits = 4'h2;
        rx_q.push_back(8'hCD);
        rx_q.push_back(8'hAB);
        exp_rx.push_back(16'hABCD);
        for (int i = 0; i < 200 && obs_rx.size() < 1; i++) @(posedge clk);
        repeat (10) @(posedge clk); #1;
        checks++; if (clr_seen != clr_base + 1) begin errors++; $display("FAIL t6_clr got %0d exp %0d", clr_seen, clr_base + 1); end
        checks++; if (clr_data !== 32'h0) begin errors++; $display("FAIL t6_clrdata got %h exp 0", clr_data); end
        checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL t6_errcnt got %0d exp 1", o_err_cnt); end
        checks++; if (obs_rx.size() != 1) begin errors++; $display("FAIL t6_words got %0d exp 1", obs_rx.size()); end
        while (obs_rx.size() != 0 && exp_rx.size() != 0) begin
            logic [RW-1:0] o, e;
            o = obs_rx.pop_front();
            e = exp_rx.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_word got %h exp %h", o, e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tx_basic();
        test_fifo_full();
        test_rx_priority();
        test_waitrequest();
        test_reset_mid_tx();
`ifdef UART_BRIDGE_ERRCHK_EN
        test_errchk();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
